debounce_ctrl: RTL
==================

// Module: debounce_ctrl
// PURPOSE
//   Control stage of the button debouncer. Synchronises the raw input and detects level changes.
//   Runs the IDLE/COUNT FSM that enables the external time counter, consumes that counter's value,
//   and raises count_finished when the input has been stable long enough.
//   Drives state/sig_change/count_finished into the counter stage; outputs the clean level.
// PARAMETERS
//   CNT_W            6   width of time_counter input
//   DEBOUNCE_CYCLES  50  stable cycles required; legal range 1..2**CNT_W-1 (elaboration error otherwise)
//   SYNC_STAGES      2   synchroniser flops on btn_raw, >=2
//   RESET_LEVEL      0   idle (released) level of the button
// PORTS
//   clk             in   1      rising-edge clock, sole clock domain
//   reset           in   1      synchronous, active-high reset
//   btn_raw         in   1      asynchronous bouncing button input
//   time_counter    in   CNT_W  cycle count from counter stage
//   state           out  1      1 = counter enabled (FSM in COUNT)
//   sig_change      out  1      synchronised input differs from last cycle's sample
//   count_finished  out  1      stability window complete; clears counter
//   btn_clean       out  1      debounced level
//   btn_rise        out  1      [DEBOUNCE_EDGE_PULSE_EN only] 1-cycle pulse, btn_clean 0->1
//   btn_fall        out  1      [DEBOUNCE_EDGE_PULSE_EN only] 1-cycle pulse, btn_clean 1->0
// BEHAVIOUR
//   - Reset: sync chain, btn_prev, btn_clean <= RESET_LEVEL; FSM <= IDLE; all pulses 0.
//     Hence state=0, sig_change=0, count_finished=0 after reset. The counter stage has no reset;
//     a stale count is harmless because COUNT is entered only on a change, which clears it.
//   - btn_sync = last sync flop; btn_prev <= btn_sync every cycle.
//   - sig_change = (btn_sync != btn_prev), combinational from registers.
//   - state = (fsm == COUNT), combinational.
//   - count_finished = (fsm==COUNT) && !sig_change && (time_counter >= DEBOUNCE_CYCLES-1).
//   - FSM transitions:
//     IDLE : btn_sync != btn_clean -> COUNT; else stay.
//     COUNT: btn_sync == btn_clean (bounced back) -> IDLE.
//            count_finished -> IDLE, btn_clean <= btn_sync.
//            otherwise stay (sig_change resets the external counter; the window restarts).
//   - Simultaneous events: sig_change has priority over the threshold (no finish that cycle).
//     Reset has priority over everything.
//   - Latency: btn_raw change to btn_sync = SYNC_STAGES cycles.
//     If edge k is the edge where btn_sync changes: COUNT entered at k+1 (counter cleared to 0 same edge).
//     Counter reaches N-1 after edge k+N; count_finished is high that cycle.
//     btn_clean updates at edge k+N+1 (N = DEBOUNCE_CYCLES).
//   - Any bounce inside the window restarts it. Glitches shorter than 1 clk after sync are filtered.
//   - Counter wrap is impossible by parameter range; >= guards against a stale value.
// CONFIGURATION
//   DEBOUNCE_EDGE_PULSE_EN defined: btn_rise/btn_fall exist, registered.
//     Each pulse is high for the 1 cycle after btn_clean changes, reset 0.
//   Undefined: ports and logic absent; btn_clean only.
// STRUCTURE
//   debounce_pkg: FSM encoding localparams ST_IDLE=1'b0, ST_COUNT=1'b1; default CNT_W/DEBOUNCE_CYCLES.
//   Sub-module sync_ff (SYNC_STAGES-deep synchroniser, sync reset to RESET_LEVEL), instantiated once.
//   Top holds btn_prev, FSM, btn_clean, optional edge pulses.
// TESTING (bench instantiates the counter stage alongside; N=50, CNT_W=6)
//   1 reset: hold reset 3 cycles with btn_raw=1.
//     -> btn_clean=0, state=0, count_finished=0; btn_clean rises 2+50+1 cycles after release.
//   2 clean press: btn_raw 0->1 and held.
//     -> state=1 for 50 cycles; count_finished single-cycle at time_counter=49; btn_clean=1 next edge.
//   3 bounce: toggle btn_raw every 7 cycles for 40 cycles, then hold 1.
//     -> sig_change each toggle, counter cleared; btn_clean rises exactly 51 cycles after the last sync change.
//   4 bounce-back: 1-cycle-wide btn_raw pulse 0->1->0.
//     -> FSM enters COUNT then returns IDLE; btn_clean stays 0; count_finished never asserted.
//   5 mid-operation reset: reset at time_counter=30 during a press.
//     -> next cycle state=0, btn_clean=0; new press requires the full 50-cycle window.
//   6 DEBOUNCE_EDGE_PULSE_EN: press then release.
//     -> btn_rise one cycle after btn_clean 0->1; btn_fall one cycle after 1->0; never both high.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared definitions for the button debouncer control stage: FSM encoding,
// default widths and a small state-decode helper.
package debounce_pkg;

    localparam int unsigned DEF_CNT_W           = 6;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 50;
    localparam int unsigned DEF_SYNC_STAGES     = 2;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_COUNT = 1'b1;

    typedef enum logic {
        FSM_IDLE  = ST_IDLE,
        FSM_COUNT = ST_COUNT
    } fsm_e;

    // True while the external time counter should be running.
    function automatic logic is_counting(fsm_e s);
        return (s == FSM_COUNT);
    endfunction

endpackage : debounce_pkg

// File: rtl/debounce_ctrl_if.sv
// Signal bundle between the debouncer control stage (slave side) and its
// environment: raw button, counter stage value and the control/clean outputs.
// Optional edge pulses exist only when DEBOUNCE_EDGE_PULSE_EN is defined.
interface debounce_ctrl_if #(
    parameter int unsigned CNT_W = debounce_pkg::DEF_CNT_W
);
    logic              btn_raw;
    logic [CNT_W-1:0]  time_counter;
    logic              state;
    logic              sig_change;
    logic              count_finished;
    logic              btn_clean;
`ifdef DEBOUNCE_EDGE_PULSE_EN
    logic              btn_rise;
    logic              btn_fall;
`endif

    // Control stage view.
    modport slave (
        input  btn_raw,
        input  time_counter,
        output state,
        output sig_change,
        output count_finished,
`ifdef DEBOUNCE_EDGE_PULSE_EN
        output btn_rise,
        output btn_fall,
`endif
        output btn_clean
    );

    // Environment / counter stage view.
    modport master (
        output btn_raw,
        output time_counter,
        input  state,
        input  sig_change,
        input  count_finished,
`ifdef DEBOUNCE_EDGE_PULSE_EN
        input  btn_rise,
        input  btn_fall,
`endif
        input  btn_clean
    );

endinterface : debounce_ctrl_if

// File: rtl/debounce_ctrl_sync_ff.sv
// Multi-flop synchroniser for the asynchronous button input; resets the whole
// chain to the released button level.
module sync_ff #(
    parameter int unsigned STAGES      = 2,
    parameter logic        RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the raw sample one flop deeper each cycle.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
    end

    // Synchroniser chain, synchronous reset to the idle level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {STAGES{RESET_LEVEL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign dout = sync_q[STAGES-1];

endmodule : sync_ff

// File: rtl/debounce_ctrl.sv
// Debouncer control stage: synchronises the button, flags level changes,
// runs the IDLE/COUNT FSM that gates the external time counter and commits
// the clean level once the input has been stable for DEBOUNCE_CYCLES cycles.
// Optional feature macro: DEBOUNCE_EDGE_PULSE_EN (registered rise/fall pulses).
module debounce_ctrl
    import debounce_pkg::*;
#(
    parameter int unsigned CNT_W           = DEF_CNT_W,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter logic        RESET_LEVEL     = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    debounce_ctrl_if.slave  bus
);

    // The counter must be able to reach DEBOUNCE_CYCLES-1 without wrapping.
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > ((1 << CNT_W) - 1)) begin : g_bad_cycles
        $error("debounce_ctrl: DEBOUNCE_CYCLES out of range for CNT_W");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("debounce_ctrl: SYNC_STAGES must be at least 2");
    end

    localparam logic [CNT_W-1:0] THRESH = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic btn_sync;
    logic btn_prev_q,  btn_prev_d;
    logic btn_clean_q, btn_clean_d;
    fsm_e fsm_q,       fsm_d;
    logic sig_change_c;
    logic count_finished_c;
    logic counting_c;
`ifdef DEBOUNCE_EDGE_PULSE_EN
    logic btn_rise_q, btn_rise_d;
    logic btn_fall_q, btn_fall_d;
`endif

    sync_ff #(
        .STAGES      (SYNC_STAGES),
        .RESET_LEVEL (RESET_LEVEL)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (bus.btn_raw),
        .dout  (btn_sync)
    );

    // Change detect and window-complete decode; a change wins over the threshold.
    always_comb begin
        counting_c       = is_counting(fsm_q);
        sig_change_c     = (btn_sync != btn_prev_q);
        count_finished_c = counting_c && !sig_change_c && (bus.time_counter >= THRESH);
    end

    // Next-state logic for the FSM, clean level and optional edge pulses.
    always_comb begin
        btn_prev_d  = btn_sync;
        fsm_d       = fsm_q;
        btn_clean_d = btn_clean_q;
        unique case (fsm_q)
            FSM_IDLE: begin
                if (btn_sync != btn_clean_q) begin
                    fsm_d = FSM_COUNT;
                end
            end
            FSM_COUNT: begin
                if (btn_sync == btn_clean_q) begin
                    fsm_d = FSM_IDLE;
                end else if (count_finished_c) begin
                    fsm_d       = FSM_IDLE;
                    btn_clean_d = btn_sync;
                end
            end
            default: begin
                fsm_d = FSM_IDLE;
            end
        endcase
`ifdef DEBOUNCE_EDGE_PULSE_EN
        btn_rise_d = btn_clean_d && !btn_clean_q;
        btn_fall_d = !btn_clean_d && btn_clean_q;
`endif
    end

    // State registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_prev_q  <= RESET_LEVEL;
            btn_clean_q <= RESET_LEVEL;
            fsm_q       <= FSM_IDLE;
`ifdef DEBOUNCE_EDGE_PULSE_EN
            btn_rise_q  <= 1'b0;
            btn_fall_q  <= 1'b0;
`endif
        end else begin
            btn_prev_q  <= btn_prev_d;
            btn_clean_q <= btn_clean_d;
            fsm_q       <= fsm_d;
`ifdef DEBOUNCE_EDGE_PULSE_EN
            btn_rise_q  <= btn_rise_d;
            btn_fall_q  <= btn_fall_d;
`endif
        end
    end

    assign bus.state          = counting_c;
    assign bus.sig_change     = sig_change_c;
    assign bus.count_finished = count_finished_c;
    assign bus.btn_clean      = btn_clean_q;
`ifdef DEBOUNCE_EDGE_PULSE_EN
    assign bus.btn_rise       = btn_rise_q;
    assign bus.btn_fall       = btn_fall_q;
`endif

endmodule : debounce_ctrl
